// File: rtl/gpu_pkg.sv
// Shared encodings and default widths for the core scheduler, fetcher and decoder.
package gpu_pkg;

  localparam int PROGRAM_MEM_ADDR_BITS_DEF = 8;
  localparam int PROGRAM_MEM_DATA_BITS_DEF = 16;
  localparam int STALL_CNT_BITS_DEF        = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-memory read channel between the fetcher (master) and the memory controller (slave).
// Handshake: valid rises with a stable address and stays high, address unchanged, until the
// first cycle ready=1; data is taken on that cycle and valid drops the cycle after.
interface instr_fetch_unit_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// One-entry fetch line buffer: last fetched address (tag), instruction word and valid bit.
module fetch_line_buffer #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fill_en,
  input  logic [ADDR_BITS-1:0] fill_addr,
  input  logic [DATA_BITS-1:0] fill_data,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 hit,
  output logic [DATA_BITS-1:0] hit_data
);
  logic                 valid_q;
  logic [ADDR_BITS-1:0] tag_q;
  logic [DATA_BITS-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_addr;
      data_q  <= fill_data;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Per-core instruction fetcher: latches current_pc on FETCH, reads program memory, holds the
// word for DECODE. Optional FETCH_LINE_BUFFER_EN adds a one-entry buffer that skips repeat reads.
module instr_fetch_unit
  import gpu_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEF,
  parameter int PROGRAM_MEM_DATA_BITS = PROGRAM_MEM_DATA_BITS_DEF,
  parameter int STALL_CNT_BITS        = STALL_CNT_BITS_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  instr_fetch_unit_if.master               mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [STALL_CNT_BITS-1:0]        stall_cycles
);
  fetcher_state_t                   state_q, state_d;
  logic                             valid_q, valid_d;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
  logic [STALL_CNT_BITS-1:0]        stall_q, stall_d;

`ifdef FETCH_LINE_BUFFER_EN
  logic                             buf_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;

  fetch_line_buffer #(
    .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS(PROGRAM_MEM_DATA_BITS)
  ) u_line_buffer (
    .clk        (clk),
    .reset      (reset),
    .fill_en    ((state_q == FETCHER_FETCHING) && mem.mem_read_ready),
    .fill_addr  (addr_q),
    .fill_data  (mem.mem_read_data),
    .lookup_addr(current_pc),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCHER_IDLE;
      valid_q <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    stall_d = stall_q;
    case (state_q)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
`ifdef FETCH_LINE_BUFFER_EN
          if (buf_hit) begin
            state_d = FETCHER_FETCHED;
            instr_d = buf_data;
          end else begin
            state_d = FETCHER_FETCHING;
            valid_d = 1'b1;
            addr_d  = current_pc;
          end
`else
          state_d = FETCHER_FETCHING;
          valid_d = 1'b1;
          addr_d  = current_pc;
`endif
        end
      end
      // The request always completes once issued, whatever core_state does meanwhile.
      FETCHER_FETCHING: begin
        if (mem.mem_read_ready) begin
          state_d = FETCHER_FETCHED;
          valid_d = 1'b0;
          instr_d = mem.mem_read_data;
        end else if (stall_q != {STALL_CNT_BITS{1'b1}}) begin
          stall_d = stall_q + 1'b1;
        end
      end
      FETCHER_FETCHED: begin
        if (core_state == CORE_DECODE) state_d = FETCHER_IDLE;
      end
      default: state_d = FETCHER_IDLE;
    endcase
  end

  assign mem.mem_read_valid   = valid_q;
  assign mem.mem_read_address = addr_q;
  assign fetcher_state        = state_q;
  assign instruction          = instr_q;
  assign stall_cycles         = stall_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; line-buffer checks run when FETCH_LINE_BUFFER_EN is defined.
module tb_instr_fetch_unit;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_stall;
  logic [15:0] exp_word;

  instr_fetch_unit_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_if ();

  instr_fetch_unit #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .STALL_CNT_BITS(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_state   (core_state),
    .current_pc   (current_pc),
    .mem          (mem_if.master),
    .fetcher_state(fetcher_state),
    .instruction  (instruction),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue FETCH for pc, hold ready low for waits cycles, then return data; pc_mid is
  // applied to current_pc while the request is outstanding.
  task automatic do_fetch(input logic [7:0] pc, input int waits, input logic [15:0] data,
                          input logic [7:0] pc_mid);
    current_pc = pc;
    core_state = CORE_FETCH;
    exp_q.push_back(data);
    step();
    core_state = CORE_IDLE;
    current_pc = pc_mid;
    check("fetching_state", fetcher_state, FETCHER_FETCHING);
    check("valid_rise", mem_if.mem_read_valid, 1);
    check("addr_latched", mem_if.mem_read_address, pc);
    for (int i = 0; i < waits; i++) begin
      mem_if.mem_read_ready = 1'b0;
      mem_if.mem_read_data  = 16'hDEAD;
      step();
      if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (i < 8 || i == waits - 1) begin
        check("valid_hold", mem_if.mem_read_valid, 1);
        check("addr_hold", mem_if.mem_read_address, pc);
        check("stall_count", stall_cycles, exp_stall);
      end
    end
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = data;
    step();
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data  = 16'h0000;
    exp_word = exp_q.pop_front();
    check("valid_drop", mem_if.mem_read_valid, 0);
    check("fetched_state", fetcher_state, FETCHER_FETCHED);
    check("instr_latched", instruction, exp_word);
    check("stall_after", stall_cycles, exp_stall);
  endtask

  task automatic release_decode();
    core_state = CORE_DECODE;
    step();
    core_state = CORE_IDLE;
    check("decode_to_idle", fetcher_state, FETCHER_IDLE);
    check("idle_valid", mem_if.mem_read_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    core_state = CORE_IDLE;
    current_pc = 8'h00;
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data  = 16'h0000;
    exp_stall = 16'd0;
    step();
    step();
    check("rst_state", fetcher_state, FETCHER_IDLE);
    check("rst_valid", mem_if.mem_read_valid, 0);
    check("rst_addr", mem_if.mem_read_address, 0);
    check("rst_instr", instruction, 0);
    check("rst_stall", stall_cycles, 0);
    reset = 1'b0;

    // Unused core_state values and a stray ready in IDLE do nothing.
    core_state = CORE_WAIT;
    current_pc = 8'h44;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = 16'h5555;
    step();
    step();
    mem_if.mem_read_ready = 1'b0;
    core_state = CORE_IDLE;
    check("idle_unused_state", fetcher_state, FETCHER_IDLE);
    check("idle_unused_valid", mem_if.mem_read_valid, 0);
    check("idle_ready_ignored", instruction, 0);

    // Basic fetch with three wait cycles.
    do_fetch(8'h05, 3, 16'h3A21, 8'h05);
    check("basic_stall3", stall_cycles, 3);

    // Hold in FETCHED under EXECUTE; ready there is ignored.
    core_state = CORE_EXECUTE;
    for (int i = 0; i < 5; i++) begin
      mem_if.mem_read_ready = (i == 2);
      mem_if.mem_read_data  = 16'h9999;
      step();
      check("hold_state", fetcher_state, FETCHER_FETCHED);
      check("hold_instr", instruction, 16'h3A21);
    end
    mem_if.mem_read_ready = 1'b0;
    release_decode();

    // Zero-wait fetch: FETCHED two edges after FETCH.
    do_fetch(8'h06, 0, 16'hF000, 8'h06);
    check("zero_wait_stall", stall_cycles, 3);
    release_decode();

    // PC change mid-fetch keeps the latched address.
    do_fetch(8'h10, 2, 16'h0C0D, 8'h20);
    check("pc_change_stall", stall_cycles, 5);
    release_decode();

    // Reset mid-fetch aborts; the following ready is ignored.
    current_pc = 8'h30;
    core_state = CORE_FETCH;
    step();
    core_state = CORE_IDLE;
    check("abort_pre_valid", mem_if.mem_read_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = 16'hBEEF;
    check("abort_valid", mem_if.mem_read_valid, 0);
    step();
    mem_if.mem_read_ready = 1'b0;
    exp_stall = 16'd0;
    check("abort_state", fetcher_state, FETCHER_IDLE);
    check("abort_valid_late", mem_if.mem_read_valid, 0);
    check("abort_addr", mem_if.mem_read_address, 0);
    check("abort_instr", instruction, 0);
    check("abort_stall", stall_cycles, 0);

    // Fetch 0x07 twice, then 0x08.
    do_fetch(8'h07, 1, 16'h1234, 8'h07);
    release_decode();
`ifdef FETCH_LINE_BUFFER_EN
    current_pc = 8'h07;
    core_state = CORE_FETCH;
    step();
    core_state = CORE_IDLE;
    check("buf_hit_state", fetcher_state, FETCHER_FETCHED);
    check("buf_hit_no_valid", mem_if.mem_read_valid, 0);
    check("buf_hit_instr", instruction, 16'h1234);
    check("buf_hit_stall", stall_cycles, exp_stall);
    release_decode();
`else
    do_fetch(8'h07, 0, 16'h1234, 8'h07);
    release_decode();
`endif
    do_fetch(8'h08, 1, 16'h4321, 8'h08);
    release_decode();

    // Long stall drives the counter into saturation.
    do_fetch(8'h09, 65540, 16'h7777, 8'h09);
    check("stall_saturated", stall_cycles, 16'hFFFF);
    release_decode();

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Per-core instruction fetcher; the consumer of the program counter.
- Takes current_pc when the core scheduler enters FETCH.
- Issues a valid/ready read to the program-memory controller and latches the returned instruction word.
- Holds the word stable for DECODE and reports its own state back to the scheduler.
- Sits between the core scheduler/PC logic and the program-memory arbiter channel.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program-memory address width; equals the PC width
PROGRAM_MEM_DATA_BITS, 16, instruction word width
STALL_CNT_BITS, 16, width of the fetch-stall performance counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
core_state  input  3  scheduler state (IDLE=000, FETCH=001, DECODE=010, REQUEST=011, WAIT=100, EXECUTE=101, UPDATE=110, DONE=111)
current_pc  input  PROGRAM_MEM_ADDR_BITS  address of the instruction to fetch
mem_read_valid  output  1  read request to the program-memory controller
mem_read_address  output  PROGRAM_MEM_ADDR_BITS  request address
mem_read_ready  input  1  response strobe from the controller
mem_read_data  input  PROGRAM_MEM_DATA_BITS  returned instruction word
fetcher_state  output  3  IDLE=000, FETCHING=001, FETCHED=010
instruction  output  PROGRAM_MEM_DATA_BITS  latched instruction word
stall_cycles  output  STALL_CNT_BITS  cumulative cycles spent in FETCHING, saturating

Behaviour:
- All outputs are registered.
- Reset values:
  - fetcher_state=IDLE; mem_read_valid=0; mem_read_address=0; instruction=0; stall_cycles=0.
  - Reset mid-fetch aborts immediately: valid drops in the next cycle, and a late ready is ignored.
- IDLE:
  - If core_state==FETCH: next edge sets mem_read_valid=1, mem_read_address=current_pc, state=FETCHING.
  - Otherwise hold all outputs.
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until ready.
  - On the first cycle with mem_read_ready=1: instruction<=mem_read_data, mem_read_valid<=0, state<=FETCHED.
  - Each cycle with ready=0 increments stall_cycles.
  - Minimum latency is core_state=FETCH at edge N, valid at N+1, ready sampled at N+1, FETCHED at N+2.
- FETCHED:
  - instruction is held.
  - If core_state==DECODE: state<=IDLE.
  - Other core_state values: stay in FETCHED.
- mem_read_ready is ignored in IDLE and FETCHED; mem_read_data is not sampled there.
- current_pc changing during FETCHING has no effect; the latched address is used.
- core_state leaving FETCH while in FETCHING does not abort the request; the handshake completes.
- stall_cycles saturates at all-ones and is never wrapped.
- Unused core_state values (REQUEST..DONE) in IDLE: no action.

Optional Feature:
FETCH_LINE_BUFFER_EN
- Defined:
  - A one-entry buffer holds the last fetched address, instruction and valid bit; valid is cleared on reset.
  - In IDLE with core_state==FETCH and buffer valid and address==current_pc: state goes directly to FETCHED with the buffered instruction, mem_read_valid stays 0, stall_cycles unchanged.
  - Every completed memory fetch refills the buffer.
- Undefined: every FETCH issues a memory read; no buffer registers exist.

Decomposition:
- Shared package (gpu_pkg): core_state encodings, fetcher_state encodings, and default widths. The scheduler and decoder already consume these.
- One natural sub-module: fetch_line_buffer (tag compare plus storage), instantiated only under FETCH_LINE_BUFFER_EN.
- All other logic stays flat.

Test Plan:
- Basic fetch: reset, current_pc=0x05, core_state=FETCH, ready returns 0x3A21 after 3 cycles -> valid=1 with address 0x05 for exactly 4 cycles; instruction=0x3A21; fetcher_state=FETCHED; stall_cycles=3.
- Zero-wait: ready=1 on the first valid cycle with data 0xF000 -> FETCHED two edges after FETCH; stall_cycles unchanged.
- Hold/release: in FETCHED, core_state=EXECUTE for 5 cycles -> stays FETCHED, instruction stable; then core_state=DECODE -> IDLE the next cycle.
- PC change mid-fetch: current_pc 0x10->0x20 while FETCHING -> mem_read_address stays 0x10 until ready.
- Reset mid-fetch: reset asserted while FETCHING, ready pulses the next cycle -> all outputs at reset values; instruction stays 0.
- With FETCH_LINE_BUFFER_EN: fetch 0x07 twice consecutively -> second fetch shows no mem_read_valid pulse and reaches FETCHED one edge after FETCH with the same instruction; fetching 0x08 issues a memory read.
